regfile_wb_buffer: RTL and testbench

Write-back buffer that sits directly upstream of the multi-port register file. It accepts one result per cycle from the execute stage over a valid/ready handshake and queues it in a small in-order FIFO. Each cycle it drains up to NUM_WRITE of the oldest entries onto the register file write ports. A lookup port reports whether a register still has a queued, not-yet-committed value, so the read stage can forward it.

---
 rtl/regfile_wb_buffer_if.sv | 36 +++
 rtl/regfile_wb_buffer.sv | 110 +++++++++++
 tb/tb_regfile_wb_buffer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_buffer_if.sv
// Bus bundle for the register-file write-back buffer: the execute-stage
// handshake, the drained write ports, the forwarding lookup and occupancy.
interface regfile_wb_buffer_if #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter int NUM_WRITE = 2,
    parameter int QDEPTH    = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(QDEPTH + 1);

    logic                       in_valid;
    logic                       in_ready;
    logic [AW-1:0]              in_addr;
    logic [WIDTH-1:0]           in_data;
    logic                       drain_en;
    logic [NUM_WRITE-1:0]       write_en;
    logic [NUM_WRITE*AW-1:0]    addr_write;
    logic [NUM_WRITE*WIDTH-1:0] data_in;
    logic [AW-1:0]              lk_addr;
    logic                       lk_hit;
    logic [WIDTH-1:0]           lk_data;
    logic [LW-1:0]              level;

    // Environment side: execute stage, read stage and drain control.
    modport master (
        output in_valid, in_addr, in_data, drain_en, lk_addr,
        input  in_ready, write_en, addr_write, data_in, lk_hit, lk_data, level
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_addr, in_data, drain_en, lk_addr,
        output in_ready, write_en, addr_write, data_in, lk_hit, lk_data, level
    );
endinterface

// File: rtl/regfile_wb_buffer.sv
// In-order write-back FIFO in front of a multi-port register file.
// Accepts one result per cycle, drains up to NUM_WRITE oldest entries per
// cycle (oldest on port 0), and offers a lookup of queued values.
// Optional feature macro: WB_FWD_EN enables the lookup comparators; when it
// is undefined lk_hit/lk_data are tied to 0 and lk_addr is ignored.
module regfile_wb_buffer #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter int NUM_WRITE = 2,
    parameter int QDEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(QDEPTH);
    localparam int LW = $clog2(QDEPTH + 1);

    logic [AW-1:0]              q_addr [QDEPTH];
    logic [WIDTH-1:0]           q_data [QDEPTH];
    logic [PW-1:0]              head;
    logic [PW-1:0]              tail;
    logic [LW-1:0]              count;

    logic                       ready;
    logic                       accept;
    logic [LW-1:0]              drain_cnt;
    logic [NUM_WRITE-1:0]       write_en;
    logic [NUM_WRITE*AW-1:0]    addr_write;
    logic [NUM_WRITE*WIDTH-1:0] data_in;
    logic                       lk_hit;
    logic [WIDTH-1:0]           lk_data;

    // Readiness ignores same-cycle drains so in_ready never depends on drain_en.
    assign ready  = (count < LW'(QDEPTH));
    assign accept = bus.in_valid && ready;

    // Number of entries leaving this cycle: min(count, NUM_WRITE) when allowed.
    always_comb begin
        drain_cnt = '0;
        if (bus.drain_en) begin
            drain_cnt = (count < LW'(NUM_WRITE)) ? count : LW'(NUM_WRITE);
        end
    end

    // Map the oldest entries onto the write ports; unused ports drive zero.
    always_comb begin
        write_en   = '0;
        addr_write = '0;
        data_in    = '0;
        for (int k = 0; k < NUM_WRITE; k++) begin
            if (LW'(k) < drain_cnt) begin
                write_en[k]                 = 1'b1;
                addr_write[k*AW +: AW]      = q_addr[head + PW'(k)];
                data_in[k*WIDTH +: WIDTH]   = q_data[head + PW'(k)];
            end
        end
    end

    // Pointer and occupancy update; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                tail <= tail + PW'(1);
            end
            head  <= head + PW'(drain_cnt);
            count <= count + LW'(accept) - drain_cnt;
        end
    end

    // Entry storage is not reset; an entry is only visible while count covers it.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_addr[tail] <= bus.in_addr;
            q_data[tail] <= bus.in_data;
        end
    end

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the last match (youngest) wins; draining entries included.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if ((LW'(i) < count) && (q_addr[head + PW'(i)] == bus.lk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = q_data[head + PW'(i)];
            end
        end
    end
`else
    logic unused_lk_addr;
    assign unused_lk_addr = ^bus.lk_addr;
    assign lk_hit         = 1'b0;
    assign lk_data        = '0;
`endif

    assign bus.in_ready   = ready;
    assign bus.write_en   = write_en;
    assign bus.addr_write = addr_write;
    assign bus.data_in    = data_in;
    assign bus.lk_hit     = lk_hit;
    assign bus.lk_data    = lk_data;
    assign bus.level      = count;
endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Bench for regfile_wb_buffer: directed vectors with literal expectations plus
// a queue-based model of the buffer and register file checked every cycle.
module tb_regfile_wb_buffer;
    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int NW    = 2;
    localparam int QD    = 4;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_wb_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_WRITE(NW), .QDEPTH(QD)) bus ();

    regfile_wb_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_WRITE(NW), .QDEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file fed by the DUT write ports; higher port applied last.
    logic [WIDTH-1:0] rf [DEPTH];
    logic [6:0]       commit_log [$];

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) rf[r] <= '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (bus.write_en[k]) begin
                    rf[bus.addr_write[k*AW +: AW]] <= bus.data_in[k*WIDTH +: WIDTH];
                    commit_log.push_back({bus.addr_write[k*AW +: AW], bus.data_in[k*WIDTH +: WIDTH]});
                end
            end
        end
    end

    // Behavioural model: plain queue of pending results and committed registers.
    typedef struct packed {
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t             mq [$];
    logic [WIDTH-1:0] mreg [DEPTH];
    bit               model_ok = 1'b0;
    int               m_n;
    bit               m_acc;
    logic [NW-1:0]    e_we;
    logic [NW*AW-1:0] e_addr;
    logic [NW*WIDTH-1:0] e_data;
    logic             e_hit;
    logic [WIDTH-1:0] e_lk;
    int               rf_diff;
    ent_t             e_pop;

    initial begin : model
        forever begin
            @(negedge clk);
            if (!rst && model_ok) begin
                m_n = 0;
                if (bus.drain_en) m_n = (mq.size() < NW) ? mq.size() : NW;
                e_we = '0; e_addr = '0; e_data = '0;
                for (int k = 0; k < m_n; k++) begin
                    e_we[k] = 1'b1;
                    e_addr[k*AW +: AW] = mq[k].a;
                    e_data[k*WIDTH +: WIDTH] = mq[k].d;
                end
                e_hit = 1'b0; e_lk = '0;
`ifdef WB_FWD_EN
                foreach (mq[i]) begin
                    if (mq[i].a == bus.lk_addr) begin
                        e_hit = 1'b1;
                        e_lk  = mq[i].d;
                    end
                end
`endif
                rf_diff = 0;
                for (int r = 0; r < DEPTH; r++) if (rf[r] !== mreg[r]) rf_diff++;
                check("m_write_en",   32'(bus.write_en),   32'(e_we));
                check("m_addr_write", 32'(bus.addr_write), 32'(e_addr));
                check("m_data_in",    32'(bus.data_in),    32'(e_data));
                check("m_lk_hit",     32'(bus.lk_hit),     32'(e_hit));
                check("m_lk_data",    32'(bus.lk_data),    32'(e_lk));
                check("m_level",      32'(bus.level),      32'(mq.size()));
                check("m_in_ready",   32'(bus.in_ready),   32'(mq.size() < QD));
                check("m_regfile_diff", 32'(rf_diff), 32'(0));
            end
            @(posedge clk);
            if (rst) begin
                mq.delete();
                for (int r = 0; r < DEPTH; r++) mreg[r] = '0;
                model_ok = 1'b1;
            end else if (model_ok) begin
                m_acc = bus.in_valid && (mq.size() < QD);
                m_n = 0;
                if (bus.drain_en) m_n = (mq.size() < NW) ? mq.size() : NW;
                for (int k = 0; k < m_n; k++) begin
                    e_pop = mq.pop_front();
                    mreg[e_pop.a] = e_pop.d;
                end
                if (m_acc) mq.push_back({bus.in_addr, bus.in_data});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int d);
        bus.in_valid = 1'b1;
        bus.in_addr  = AW'(a);
        bus.in_data  = WIDTH'(d);
        tick();
    endtask

    int base;
    int wexp;

    initial begin : stim
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0;
        bus.drain_en = 1'b0; bus.lk_addr = '0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_level",    32'(bus.level),    32'(0));
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
        check("rst_write_en", 32'(bus.write_en), 32'(0));
        check("rst_lk_hit",   32'(bus.lk_hit),   32'(0));
        check("rst_lk_data",  32'(bus.lk_data),  32'(0));

        // Single write: visible on port 0 one cycle after acceptance.
        bus.drain_en = 1'b1;
        push(3, 4'hA);
        bus.in_valid = 1'b0;
        #1;
        check("single_we",    32'(bus.write_en),        32'(1));
        check("single_addr",  32'(bus.addr_write[2:0]), 32'(3));
        check("single_data",  32'(bus.data_in[3:0]),    32'(4'hA));
        check("single_level", 32'(bus.level),           32'(1));
        tick();
        check("single_level0", 32'(bus.level), 32'(0));
        check("single_rf3",    32'(rf[3]),     32'(4'hA));

        // Fill with draining held, then release.
        bus.drain_en = 1'b0;
        for (int i = 0; i < 4; i++) push(i, 4 + i);
        bus.in_valid = 1'b1; bus.in_addr = 3'd4; bus.in_data = 4'h9;
        #1;
        check("fill_level",  32'(bus.level),    32'(4));
        check("fill_ready",  32'(bus.in_ready), 32'(0));
        tick();
        check("fill_held",   32'(bus.level),    32'(4));
        check("fill_no_we",  32'(bus.write_en), 32'(0));
        bus.drain_en = 1'b1;
        #1;
        check("fill_d1_we",   32'(bus.write_en),   32'(3));
        check("fill_d1_addr", 32'(bus.addr_write), 32'(6'b001_000));
        tick();
        check("fill_d2_level", 32'(bus.level),      32'(2));
        check("fill_d2_ready", 32'(bus.in_ready),   32'(1));
        check("fill_d2_addr",  32'(bus.addr_write), 32'(6'b011_010));
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("fill_d3_level", 32'(bus.level),           32'(1));
        check("fill_d3_we",    32'(bus.write_en),        32'(1));
        check("fill_d3_addr",  32'(bus.addr_write[2:0]), 32'(4));
        check("fill_d3_data",  32'(bus.data_in[3:0]),    32'(9));
        tick();
        check("fill_empty", 32'(bus.level), 32'(0));

        // Same-address collision: younger value on higher port wins.
        bus.drain_en = 1'b0;
        push(5, 1);
        push(5, 2);
        bus.in_valid = 1'b0;
        bus.drain_en = 1'b1;
        #1;
        check("coll_we",   32'(bus.write_en),   32'(3));
        check("coll_addr", 32'(bus.addr_write), 32'(6'b101_101));
        check("coll_data", 32'(bus.data_in),    32'(8'h21));
        tick();
        check("coll_rf5",   32'(rf[5]),     32'(2));
        check("coll_level", 32'(bus.level), 32'(0));

        // Lookup returns the youngest queued value.
        bus.drain_en = 1'b0;
        push(2, 3);
        push(2, 7);
        bus.in_valid = 1'b0;
        bus.lk_addr  = 3'd2;
        #1;
`ifdef WB_FWD_EN
        check("fwd_hit",  32'(bus.lk_hit),  32'(1));
        check("fwd_data", 32'(bus.lk_data), 32'(7));
`else
        check("fwd_hit",  32'(bus.lk_hit),  32'(0));
        check("fwd_data", 32'(bus.lk_data), 32'(0));
`endif
        bus.lk_addr = 3'd4;
        #1;
        check("fwd_miss_hit",  32'(bus.lk_hit),  32'(0));
        check("fwd_miss_data", 32'(bus.lk_data), 32'(0));
        bus.drain_en = 1'b1;
        tick();
        check("fwd_drained", 32'(bus.level), 32'(0));

        // Back-to-back accepts with draining: wraps pointers, nothing lost.
        base = commit_log.size();
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = AW'(i % 8);
            bus.in_data  = WIDTH'((i * 3) % 16);
            #1;
            check("wrap_ready", 32'(bus.in_ready),    32'(1));
            check("wrap_level", 32'(bus.level <= 2),  32'(1));
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (2) tick();
        check("wrap_count", 32'(commit_log.size() - base), 32'(20));
        for (int i = 0; i < 20; i++) begin
            wexp = ((i % 8) << 4) | ((i * 3) % 16);
            if (base + i < commit_log.size())
                check("wrap_order", 32'(commit_log[base + i]), 32'(wexp));
            else
                check("wrap_order", 32'hFFFF_FFFF, 32'(wexp));
        end

        // Reset with queued entries: discarded, no writes, accept ignored.
        bus.drain_en = 1'b0;
        push(1, 1);
        push(6, 2);
        push(7, 3);
        bus.in_valid = 1'b0;
        #1;
        check("mid_level3", 32'(bus.level), 32'(3));
        base = commit_log.size();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_addr = 3'd6; bus.in_data = 4'hF;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.drain_en = 1'b1;
        bus.lk_addr  = 3'd6;
        #1;
        check("mid_level0", 32'(bus.level),    32'(0));
        check("mid_we",     32'(bus.write_en), 32'(0));
        check("mid_lk_hit", 32'(bus.lk_hit),   32'(0));
        check("mid_ready",  32'(bus.in_ready), 32'(1));
        tick();
        check("mid_still0",  32'(bus.level), 32'(0));
        check("mid_nowrite", 32'(commit_log.size() - base), 32'(0));

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
